// File: rtl/lpddr4_ctrl_pkg.sv
// Shared LPDDR4 controller definitions: command encodings, address bit indices, refresher FSM states.
package lpddr4_ctrl_pkg;

  localparam int unsigned CMD_W   = 3;
  // Command encodings as {cas, ras, we}
  localparam logic [CMD_W-1:0] CMD_NOP = 3'b000;
  localparam logic [CMD_W-1:0] CMD_PRE = 3'b011;
  localparam logic [CMD_W-1:0] CMD_REF = 3'b110;

  // A10 selects all-bank (1) or single-bank (0) for PRE/REF
  localparam int unsigned A10_IDX = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_PRE,
    S_WAIT_RP,
    S_REF,
    S_WAIT_RFC,
    S_NEXT,
    S_DONE
  } ref_state_e;

endpackage

// File: rtl/refresh_debt_tracker.sv
// Per-rank refresh debt: tREFI tick timer, saturating debt counters, sticky overflow, round-robin pick.
module refresh_debt_tracker #(
  parameter int unsigned NRANKS   = 2,
  parameter int unsigned TIMER_W  = 12,
  parameter int unsigned MAX_DEBT = 8,
  parameter int unsigned DEBT_W   = 4,
  parameter int unsigned RANK_W   = 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [TIMER_W-1:0]             i_trefi,
  input  logic [DEBT_W-1:0]              i_postpone,
  input  logic                           i_grant,
  input  logic                           i_done,
  input  logic [RANK_W-1:0]              i_done_rank,
  output logic                           o_req_any_c,
  output logic [RANK_W-1:0]              o_req_rank_c,
  output logic [NRANKS-1:0][DEBT_W-1:0]  o_debt,
  output logic                           o_overflow
);

  logic                          r_tmr_init;
  logic [TIMER_W-1:0]            r_timer;
  logic [NRANKS-1:0][DEBT_W-1:0] r_debt;
  logic                          r_overflow;
  logic [RANK_W-1:0]             r_rr;

  logic [TIMER_W-1:0]            w_timer;
  logic                          w_tick;
  logic [DEBT_W-1:0]             w_thresh;
  logic [NRANKS-1:0]             w_elig;
  logic [NRANKS-1:0]             w_dec;
  logic [NRANKS-1:0][DEBT_W-1:0] w_debt_n;
  logic                          w_ovf_set;
  logic [RANK_W-1:0]             w_idx;

  // First cycle out of reset behaves as if the timer held tREFI-1
  assign w_timer  = r_tmr_init ? r_timer : TIMER_W'(i_trefi - TIMER_W'(1));
  assign w_tick   = (w_timer == '0);
  assign w_thresh = (i_postpone == '0) ? DEBT_W'(1) : i_postpone;

  assign o_debt     = r_debt;
  assign o_overflow = r_overflow;

  // Debt next-state: tick and completion on the same rank cancel; tick saturates at MAX_DEBT
  always_comb begin
    w_debt_n  = r_debt;
    w_ovf_set = 1'b0;
    w_dec     = '0;
    w_elig    = '0;
    for (int i = 0; i < NRANKS; i++) begin
      w_dec[i]  = i_done && (i_done_rank == RANK_W'(i));
      w_elig[i] = (r_debt[i] >= w_thresh);
      if (w_tick && (r_debt[i] == DEBT_W'(MAX_DEBT))) w_ovf_set = 1'b1;
      if (w_tick && !w_dec[i]) begin
        if (r_debt[i] != DEBT_W'(MAX_DEBT)) w_debt_n[i] = r_debt[i] + DEBT_W'(1);
      end else if (!w_tick && w_dec[i] && (r_debt[i] != '0)) begin
        w_debt_n[i] = r_debt[i] - DEBT_W'(1);
      end
    end
  end

  // Round-robin search for an eligible rank starting at the rr pointer
  always_comb begin
    o_req_any_c  = 1'b0;
    o_req_rank_c = '0;
    w_idx        = '0;
    for (int k = 0; k < NRANKS; k++) begin
      w_idx = RANK_W'((32'(r_rr) + 32'(k)) % NRANKS);
      if (!o_req_any_c && w_elig[w_idx]) begin
        o_req_any_c  = 1'b1;
        o_req_rank_c = w_idx;
      end
    end
  end

  // Timer, debts, overflow and rr pointer state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tmr_init <= 1'b0;
      r_timer    <= '0;
      r_debt     <= '0;
      r_overflow <= 1'b0;
      r_rr       <= '0;
    end else begin
      r_tmr_init <= 1'b1;
      r_timer    <= w_tick ? TIMER_W'(i_trefi - TIMER_W'(1)) : w_timer - TIMER_W'(1);
      r_debt     <= w_debt_n;
      r_overflow <= r_overflow | w_ovf_set;
      if (i_grant) begin
        r_rr <= (o_req_rank_c == RANK_W'(NRANKS - 1)) ? '0 : o_req_rank_c + RANK_W'(1);
      end
    end
  end

endmodule

// File: rtl/refresher_multirank_pb.sv
// Multi-rank LPDDR4 refresh scheduler: REFab or REFpb bursts driven by per-rank refresh debt.
module refresher_multirank_pb
  import lpddr4_ctrl_pkg::*;
#(
  parameter int unsigned NRANKS   = 2,
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned BA_W     = 3,
  parameter int unsigned TCFG_W   = 8,
  parameter int unsigned TIMER_W  = 12,
  parameter int unsigned MAX_DEBT = 8,
  localparam int unsigned RANK_W  = (NRANKS > 1) ? $clog2(NRANKS) : 1,
  localparam int unsigned DEBT_W  = $clog2(MAX_DEBT + 1)
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic               cmd_last,
  output logic [ADDR_W-1:0]  cmd_payload_a,
  output logic [BA_W-1:0]    cmd_payload_ba,
  output logic [RANK_W-1:0]  cmd_payload_rank,
  output logic               cmd_payload_cas,
  output logic               cmd_payload_ras,
  output logic               cmd_payload_we,
  input  logic [TCFG_W-1:0]  ref_tRP_cfg,
  input  logic [TCFG_W-1:0]  ref_tRFC_cfg,
  input  logic [TIMER_W-1:0] ref_tREFI_cfg,
  input  logic [DEBT_W-1:0]  ref_POSTPONE_cfg,
  input  logic               ref_mode_pb,
  output logic               debt_overflow
);

  ref_state_e                  r_state, w_state_n;
  logic [RANK_W-1:0]           r_rank, w_rank_n;
  logic                        r_mode, w_mode_n;
  logic [TCFG_W-1:0]           r_cnt, w_cnt_n;
  logic [NRANKS-1:0][BA_W-1:0] r_bank_ptr;

  logic                        r_valid, r_last;
  logic [CMD_W-1:0]            r_cmd;
  logic [ADDR_W-1:0]           r_a;
  logic [BA_W-1:0]             r_ba;
  logic [RANK_W-1:0]           r_rank_o;

  logic                        w_valid_n, w_last_n;
  logic [CMD_W-1:0]            w_cmd_n;
  logic [ADDR_W-1:0]           w_a_n;
  logic [BA_W-1:0]             w_ba_n;
  logic [RANK_W-1:0]           w_rank_o_n;

  logic                        w_grant, w_done;
  logic                        w_req_any_c;
  logic [RANK_W-1:0]           w_req_rank_c;
  logic [NRANKS-1:0][DEBT_W-1:0] w_debt;

  refresh_debt_tracker #(
    .NRANKS   (NRANKS),
    .TIMER_W  (TIMER_W),
    .MAX_DEBT (MAX_DEBT),
    .DEBT_W   (DEBT_W),
    .RANK_W   (RANK_W)
  ) u_tracker (
    .i_clk        (sys_clk),
    .i_rst_n      (sys_rst_n),
    .i_trefi      (ref_tREFI_cfg),
    .i_postpone   (ref_POSTPONE_cfg),
    .i_grant      (w_grant),
    .i_done       (w_done),
    .i_done_rank  (r_rank),
    .o_req_any_c  (w_req_any_c),
    .o_req_rank_c (w_req_rank_c),
    .o_debt       (w_debt),
    .o_overflow   (debt_overflow)
  );

  // Next-state: PRE -> tRP -> REF -> tRFC -> NEXT; waits exit when the counter would reach 0
  always_comb begin
    w_state_n = r_state;
    w_rank_n  = r_rank;
    w_mode_n  = r_mode;
    w_cnt_n   = r_cnt;
    w_grant   = 1'b0;
    w_done    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req_any_c) begin
          w_grant   = 1'b1;
          w_rank_n  = w_req_rank_c;
          w_mode_n  = ref_mode_pb;
          w_state_n = S_REQ;
        end
      end
      S_REQ:      if (cmd_ready) w_state_n = S_PRE;
      S_PRE: begin
        w_cnt_n   = ref_tRP_cfg - TCFG_W'(1);
        w_state_n = (ref_tRP_cfg <= TCFG_W'(1)) ? S_REF : S_WAIT_RP;
      end
      S_WAIT_RP: begin
        w_cnt_n = r_cnt - TCFG_W'(1);
        if (r_cnt <= TCFG_W'(1)) w_state_n = S_REF;
      end
      S_REF: begin
        w_cnt_n = ref_tRFC_cfg - TCFG_W'(1);
        if (ref_tRFC_cfg <= TCFG_W'(1)) begin
          w_done    = 1'b1;
          w_state_n = S_NEXT;
        end else begin
          w_state_n = S_WAIT_RFC;
        end
      end
      S_WAIT_RFC: begin
        w_cnt_n = r_cnt - TCFG_W'(1);
        if (r_cnt <= TCFG_W'(1)) begin
          w_done    = 1'b1;
          w_state_n = S_NEXT;
        end
      end
      S_NEXT:     w_state_n = (w_debt[r_rank] != '0) ? S_PRE : S_DONE;
      S_DONE:     w_state_n = S_IDLE;
      default:    w_state_n = S_IDLE;
    endcase
  end

  // Output values for the upcoming state so the registered bus lines up with the FSM
  always_comb begin
    w_valid_n  = (w_state_n != S_IDLE) && (w_state_n != S_DONE);
    w_last_n   = (w_state_n == S_DONE);
    w_cmd_n    = CMD_NOP;
    w_a_n      = '0;
    w_ba_n     = '0;
    w_rank_o_n = '0;
    if ((w_state_n == S_PRE) || (w_state_n == S_REF)) begin
      w_cmd_n    = (w_state_n == S_PRE) ? CMD_PRE : CMD_REF;
      w_rank_o_n = w_rank_n;
      if (w_mode_n) w_ba_n = r_bank_ptr[w_rank_n];
      else          w_a_n[A10_IDX] = 1'b1;
    end
  end

  // State, counters, bank pointers and registered command bus
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= S_IDLE;
      r_rank     <= '0;
      r_mode     <= 1'b0;
      r_cnt      <= '0;
      r_bank_ptr <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_cmd      <= CMD_NOP;
      r_a        <= '0;
      r_ba       <= '0;
      r_rank_o   <= '0;
    end else begin
      r_state  <= w_state_n;
      r_rank   <= w_rank_n;
      r_mode   <= w_mode_n;
      r_cnt    <= w_cnt_n;
      if (w_done && r_mode) r_bank_ptr[r_rank] <= r_bank_ptr[r_rank] + BA_W'(1);
      r_valid  <= w_valid_n;
      r_last   <= w_last_n;
      r_cmd    <= w_cmd_n;
      r_a      <= w_a_n;
      r_ba     <= w_ba_n;
      r_rank_o <= w_rank_o_n;
    end
  end

  assign cmd_valid        = r_valid;
  assign cmd_last         = r_last;
  assign cmd_payload_a    = r_a;
  assign cmd_payload_ba   = r_ba;
  assign cmd_payload_rank = r_rank_o;
  assign cmd_payload_cas  = r_cmd[2];
  assign cmd_payload_ras  = r_cmd[1];
  assign cmd_payload_we   = r_cmd[0];

endmodule

// File: tb/tb_refresher_multirank_pb.sv
// Directed bench for refresher_multirank_pb: event log of PRE/REF/last/valid with hand-computed timing.
module tb_refresher_multirank_pb;

  localparam int ADDR_W = 17, BA_W = 3, RANK_W = 1, TCFG_W = 8, TIMER_W = 12, DEBT_W = 4;
  localparam int EV_PRE = 0, EV_REF = 1, EV_LAST = 2, EV_VALID = 3;
  localparam int A10 = 1024;

  logic               sys_clk = 1'b0;
  logic               sys_rst_n = 1'b0;
  logic               cmd_valid, cmd_ready, cmd_last;
  logic [ADDR_W-1:0]  cmd_payload_a;
  logic [BA_W-1:0]    cmd_payload_ba;
  logic [RANK_W-1:0]  cmd_payload_rank;
  logic               cmd_payload_cas, cmd_payload_ras, cmd_payload_we;
  logic [TCFG_W-1:0]  ref_tRP_cfg, ref_tRFC_cfg;
  logic [TIMER_W-1:0] ref_tREFI_cfg;
  logic [DEBT_W-1:0]  ref_POSTPONE_cfg;
  logic               ref_mode_pb;
  logic               debt_overflow;

  refresher_multirank_pb dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_last(cmd_last),
    .cmd_payload_a(cmd_payload_a), .cmd_payload_ba(cmd_payload_ba), .cmd_payload_rank(cmd_payload_rank),
    .cmd_payload_cas(cmd_payload_cas), .cmd_payload_ras(cmd_payload_ras), .cmd_payload_we(cmd_payload_we),
    .ref_tRP_cfg(ref_tRP_cfg), .ref_tRFC_cfg(ref_tRFC_cfg), .ref_tREFI_cfg(ref_tREFI_cfg),
    .ref_POSTPONE_cfg(ref_POSTPONE_cfg), .ref_mode_pb(ref_mode_pb), .debt_overflow(debt_overflow)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t_base  = 0;
  int q_base  = 0;

  typedef struct {
    int kind;
    int t;
    int rank;
    int ba;
    int a;
  } ev_t;
  ev_t evq[$];

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Log bus events on the falling edge, away from the active edge
  logic mon_prev_valid = 1'b0;
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      mon_prev_valid = 1'b0;
    end else begin
      if ({cmd_payload_cas, cmd_payload_ras, cmd_payload_we} == 3'b011)
        evq.push_back('{EV_PRE, cyc, int'(cmd_payload_rank), int'(cmd_payload_ba), int'(cmd_payload_a)});
      if ({cmd_payload_cas, cmd_payload_ras, cmd_payload_we} == 3'b110)
        evq.push_back('{EV_REF, cyc, int'(cmd_payload_rank), int'(cmd_payload_ba), int'(cmd_payload_a)});
      if (cmd_last) evq.push_back('{EV_LAST, cyc, 0, 0, 0});
      if (cmd_valid && !mon_prev_valid) evq.push_back('{EV_VALID, cyc, 0, 0, 0});
      mon_prev_valid = cmd_valid;
    end
  end

  function automatic int find_ev(input int kind, input int rank, input int from);
    if (from < 0) return -1;
    for (int i = from; i < evq.size(); i++)
      if (evq[i].kind == kind && (rank < 0 || evq[i].rank == rank)) return i;
    return -1;
  endfunction

  function automatic int rel(input int idx);
    if (idx < 0 || idx >= evq.size()) return -99999;
    return evq[idx].t - t_base;
  endfunction

  function automatic int f_rank(input int idx);
    if (idx < 0 || idx >= evq.size()) return -1;
    return evq[idx].rank;
  endfunction

  function automatic int f_ba(input int idx);
    if (idx < 0 || idx >= evq.size()) return -1;
    return evq[idx].ba;
  endfunction

  function automatic int f_a(input int idx);
    if (idx < 0 || idx >= evq.size()) return -1;
    return evq[idx].a;
  endfunction

  function automatic int count_ev(input int kind, input int rank, input int from, input int to);
    int n = 0;
    if (from < 0 || to < 0) return -1;
    for (int i = from; i < to && i < evq.size(); i++)
      if (evq[i].kind == kind && (rank < 0 || evq[i].rank == rank)) n++;
    return n;
  endfunction

  task automatic do_reset(input int trefi, input int post, input int trp, input int trfc,
                          input logic mode, input logic rdy);
    @(negedge sys_clk);
    sys_rst_n        = 1'b0;
    ref_tREFI_cfg    = TIMER_W'(trefi);
    ref_POSTPONE_cfg = DEBT_W'(post);
    ref_tRP_cfg      = TCFG_W'(trp);
    ref_tRFC_cfg     = TCFG_W'(trfc);
    ref_mode_pb      = mode;
    cmd_ready        = rdy;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    t_base    = cyc;
    q_base    = evq.size();
  endtask

  // Advance until the sample after active edge k (relative to reset release)
  task automatic run_to(input int k);
    while (cyc - t_base < k) @(negedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset(20, 1, 3, 10, 1'b0, 1'b1);
    run_to(5);
    n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b expected 0", cmd_valid); end
    n_tests++; if (cmd_last !== 1'b0) begin n_fail++; $display("FAIL rst_last: got %0b expected 0", cmd_last); end
    n_tests++; if ({cmd_payload_cas, cmd_payload_ras, cmd_payload_we} !== 3'b000) begin n_fail++;
      $display("FAIL rst_cmd: got %b expected 000", {cmd_payload_cas, cmd_payload_ras, cmd_payload_we}); end
    n_tests++; if (cmd_payload_a !== '0 || cmd_payload_ba !== '0 || cmd_payload_rank !== '0) begin n_fail++;
      $display("FAIL rst_payload: got a=%0d ba=%0d rank=%0d expected 0", cmd_payload_a, cmd_payload_ba, cmd_payload_rank); end
    n_tests++; if (debt_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %0b expected 0", debt_overflow); end
    run_to(20);
    n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid_pre_tick: got %0b expected 0", cmd_valid); end
    run_to(21);
    n_tests++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL rst_valid_post_tick: got %0b expected 1", cmd_valid); end
  endtask

  task automatic test_ab_basic();
    int iv, ip, ir, il, ip2;
    do_reset(20, 1, 3, 10, 1'b0, 1'b1);
    run_to(45);
    iv  = find_ev(EV_VALID, -1, q_base);
    ip  = find_ev(EV_PRE, -1, q_base);
    ir  = find_ev(EV_REF, -1, ip);
    il  = find_ev(EV_LAST, -1, ir);
    ip2 = find_ev(EV_PRE, -1, ip + 1);
    n_tests++; if (rel(iv) !== 21) begin n_fail++; $display("FAIL ab_valid_time: got %0d expected 21", rel(iv)); end
    n_tests++; if (rel(ip) !== 22) begin n_fail++; $display("FAIL ab_pre_time: got %0d expected 22", rel(ip)); end
    n_tests++; if (f_a(ip) !== A10 || f_ba(ip) !== 0 || f_rank(ip) !== 0) begin n_fail++;
      $display("FAIL ab_pre_payload: got a=%0d ba=%0d rank=%0d expected a=%0d ba=0 rank=0", f_a(ip), f_ba(ip), f_rank(ip), A10); end
    n_tests++; if (rel(ir) - rel(ip) !== 3) begin n_fail++; $display("FAIL ab_trp: got %0d expected 3", rel(ir) - rel(ip)); end
    n_tests++; if (f_a(ir) !== A10 || f_rank(ir) !== 0) begin n_fail++;
      $display("FAIL ab_ref_payload: got a=%0d rank=%0d expected a=%0d rank=0", f_a(ir), f_rank(ir), A10); end
    n_tests++; if (rel(il) - rel(ir) !== 11) begin n_fail++; $display("FAIL ab_last_delay: got %0d expected 11", rel(il) - rel(ir)); end
    n_tests++; if (ip2 < il) begin n_fail++; $display("FAIL ab_single_pre: got index %0d expected after %0d", ip2, il); end
    n_tests++; if (f_rank(ip2) !== 1 || rel(ip2) !== 39) begin n_fail++;
      $display("FAIL ab_rank1_pre: got rank=%0d t=%0d expected rank=1 t=39", f_rank(ip2), rel(ip2)); end
  endtask

  task automatic test_postpone();
    int iv, il, ip, ir4, ip1;
    do_reset(100, 4, 3, 10, 1'b0, 1'b1);
    run_to(470);
    iv = find_ev(EV_VALID, -1, q_base);
    il = find_ev(EV_LAST, -1, q_base);
    n_tests++; if (rel(iv) !== 401) begin n_fail++; $display("FAIL pp_valid_time: got %0d expected 401", rel(iv)); end
    ip = q_base;
    for (int k = 0; k < 4; k++) begin
      ip = find_ev(EV_PRE, 0, ip);
      n_tests++; if (rel(ip) !== 402 + 14 * k) begin n_fail++;
        $display("FAIL pp_pre%0d_time: got %0d expected %0d", k, rel(ip), 402 + 14 * k); end
      if (ip >= 0) ip++;
    end
    n_tests++; if (count_ev(EV_PRE, -1, q_base, il) !== 4) begin n_fail++;
      $display("FAIL pp_pre_count: got %0d expected 4", count_ev(EV_PRE, -1, q_base, il)); end
    n_tests++; if (rel(il) !== 458) begin n_fail++; $display("FAIL pp_last_time: got %0d expected 458", rel(il)); end
    ir4 = find_ev(EV_REF, 0, find_ev(EV_PRE, 0, ip - 1));
    n_tests++; if (rel(il) - rel(ir4) !== 11) begin n_fail++; $display("FAIL pp_last_after_ref: got %0d expected 11", rel(il) - rel(ir4)); end
    ip1 = find_ev(EV_PRE, -1, il);
    n_tests++; if (f_rank(ip1) !== 1 || rel(ip1) !== 461) begin n_fail++;
      $display("FAIL pp_rank1_pre: got rank=%0d t=%0d expected rank=1 t=461", f_rank(ip1), rel(ip1)); end
  endtask

  task automatic test_pb_banks();
    int ip, ir, ip1;
    do_reset(40, 1, 2, 5, 1'b1, 1'b1);
    run_to(500);
    ip = q_base;
    for (int k = 0; k < 10; k++) begin
      ip = find_ev(EV_PRE, 0, ip);
      ir = find_ev(EV_REF, 0, ip);
      n_tests++; if (f_ba(ip) !== k % 8 || f_a(ip) !== 0) begin n_fail++;
        $display("FAIL pb_pre%0d: got ba=%0d a=%0d expected ba=%0d a=0", k, f_ba(ip), f_a(ip), k % 8); end
      n_tests++; if (f_ba(ir) !== k % 8 || f_a(ir) !== 0) begin n_fail++;
        $display("FAIL pb_ref%0d: got ba=%0d a=%0d expected ba=%0d a=0", k, f_ba(ir), f_a(ir), k % 8); end
      if (ip >= 0) ip++;
    end
    ip1 = find_ev(EV_PRE, 1, q_base);
    n_tests++; if (f_ba(ip1) !== 0) begin n_fail++; $display("FAIL pb_rank1_ba: got %0d expected 0", f_ba(ip1)); end
  endtask

  task automatic test_overflow();
    int ip, il;
    do_reset(100, 1, 2, 4, 1'b0, 1'b0);
    run_to(105);
    n_tests++; if (cmd_valid !== 1'b1 || {cmd_payload_cas, cmd_payload_ras, cmd_payload_we} !== 3'b000) begin n_fail++;
      $display("FAIL ov_req_hold: got valid=%0b cmd=%b expected valid=1 cmd=000", cmd_valid,
               {cmd_payload_cas, cmd_payload_ras, cmd_payload_we}); end
    run_to(895);
    n_tests++; if (debt_overflow !== 1'b0) begin n_fail++; $display("FAIL ov_before_9th: got %0b expected 0", debt_overflow); end
    run_to(901);
    n_tests++; if (debt_overflow !== 1'b1) begin n_fail++; $display("FAIL ov_after_9th: got %0b expected 1", debt_overflow); end
    cmd_ready = 1'b1;
    run_to(970);
    ip = find_ev(EV_PRE, -1, q_base);
    il = find_ev(EV_LAST, -1, q_base);
    n_tests++; if (rel(ip) !== 902) begin n_fail++; $display("FAIL ov_first_pre: got %0d expected 902", rel(ip)); end
    n_tests++; if (count_ev(EV_PRE, 0, q_base, il) !== 8) begin n_fail++;
      $display("FAIL ov_refresh_count: got %0d expected 8", count_ev(EV_PRE, 0, q_base, il)); end
    n_tests++; if (rel(il) !== 958) begin n_fail++; $display("FAIL ov_last_time: got %0d expected 958", rel(il)); end
    n_tests++; if (debt_overflow !== 1'b1) begin n_fail++; $display("FAIL ov_sticky: got %0b expected 1", debt_overflow); end
  endtask

  task automatic test_tick_coincident();
    int ip, ir, ip2, il;
    do_reset(20, 1, 3, 15, 1'b0, 1'b1);
    run_to(65);
    ip  = find_ev(EV_PRE, 0, q_base);
    ir  = find_ev(EV_REF, 0, ip);
    ip2 = find_ev(EV_PRE, 0, ir);
    il  = find_ev(EV_LAST, -1, q_base);
    n_tests++; if (rel(ir) !== 25) begin n_fail++; $display("FAIL tc_ref_time: got %0d expected 25", rel(ir)); end
    n_tests++; if (rel(ip2) !== 41) begin n_fail++; $display("FAIL tc_loop_pre: got %0d expected 41", rel(ip2)); end
    n_tests++; if (il < ip2) begin n_fail++; $display("FAIL tc_no_early_last: got index %0d expected after %0d", il, ip2); end
    n_tests++; if (rel(il) !== 60) begin n_fail++; $display("FAIL tc_last_time: got %0d expected 60", rel(il)); end
  endtask

  task automatic test_reset_midburst();
    int iv, il;
    do_reset(20, 1, 6, 10, 1'b0, 1'b1);
    run_to(24);
    n_tests++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL rm_in_burst: got %0b expected 1", cmd_valid); end
    sys_rst_n = 1'b0;
    #1;
    n_tests++; if (cmd_valid !== 1'b0 || cmd_last !== 1'b0 || cmd_payload_a !== '0 ||
                   {cmd_payload_cas, cmd_payload_ras, cmd_payload_we} !== 3'b000) begin n_fail++;
      $display("FAIL rm_async_clear: got valid=%0b last=%0b a=%0d cmd=%b expected all 0", cmd_valid, cmd_last,
               cmd_payload_a, {cmd_payload_cas, cmd_payload_ras, cmd_payload_we}); end
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    t_base    = cyc;
    q_base    = evq.size();
    run_to(30);
    iv = find_ev(EV_VALID, -1, q_base);
    il = find_ev(EV_LAST, -1, q_base);
    n_tests++; if (rel(iv) !== 21) begin n_fail++; $display("FAIL rm_debt_cleared: got %0d expected 21", rel(iv)); end
    n_tests++; if (il !== -1) begin n_fail++; $display("FAIL rm_no_last: got index %0d expected -1", il); end
  endtask

  initial begin
    cmd_ready        = 1'b1;
    ref_tRP_cfg      = TCFG_W'(3);
    ref_tRFC_cfg     = TCFG_W'(10);
    ref_tREFI_cfg    = TIMER_W'(20);
    ref_POSTPONE_cfg = DEBT_W'(1);
    ref_mode_pb      = 1'b0;
    test_reset();
    test_ab_basic();
    test_postpone();
    test_pb_banks();
    test_overflow();
    test_tick_coincident();
    test_reset_midburst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
